// File: rtl/pmod_enc_axil_regs.sv
// AXI4-Lite responder exposing four 32-bit registers to the PmodENC core.
// Define PMOD_ENC_WSTRB_EN to honour WSTRB byte lanes; otherwise all bytes write.
module pmod_enc_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  logic          aw_held_q, aw_held_d;
  logic [1:0]    aw_idx_q, aw_idx_d;
  logic          w_held_q, w_held_d;
  logic [DW-1:0] w_data_q, w_data_d;
  logic [SW-1:0] w_strb_q, w_strb_d;
  logic          bvalid_q, bvalid_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [DW-1:0] regs_q [4];
  logic [DW-1:0] regs_d [4];

  logic          aw_hs, w_hs, ar_hs, commit;
  logic [1:0]    widx;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR, S_AXI_ARADDR};

  assign S_AXI_AWREADY = !S_AXI_ARESET && !aw_held_q && !bvalid_q;
  assign S_AXI_WREADY  = !S_AXI_ARESET && !w_held_q && !bvalid_q;
  assign S_AXI_ARREADY = !S_AXI_ARESET && !rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign reg0_o = regs_q[0];
  assign reg1_o = regs_q[1];
  assign reg2_o = regs_q[2];
  assign reg3_o = regs_q[3];

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // A live handshake counts as held, so the commit lands on its own edge
  assign commit = (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign widx   = aw_hs ? S_AXI_AWADDR[3:2] : aw_idx_q;
  assign wdata  = w_hs ? S_AXI_WDATA : w_data_q;
`ifdef PMOD_ENC_WSTRB_EN
  assign wstrb  = w_hs ? S_AXI_WSTRB : w_strb_q;
`else
  assign wstrb  = {SW{1'b1}};
`endif

  always_comb begin
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    regs_d    = regs_q;
    if (commit) begin
      for (int i = 0; i < SW; i++) begin
        if (wstrb[i]) regs_d[widx][8*i +: 8] = wdata[8*i +: 8];
      end
      bvalid_d  = 1'b1;
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held_d = 1'b1;
        aw_idx_d  = S_AXI_AWADDR[3:2];
      end
      if (w_hs) begin
        w_held_d = 1'b1;
        w_data_d = S_AXI_WDATA;
        w_strb_d = S_AXI_WSTRB;
      end
    end
    if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
  end

  // Read samples regs_q, so a same-edge write returns the old value
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = regs_q[S_AXI_ARADDR[3:2]];
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      regs_q    <= regs_d;
    end
  end

endmodule

// File: tb/tb_pmod_enc_axil_regs.sv
// Bench for pmod_enc_axil_regs: directed AXI4-Lite traffic with a
// response scoreboard drained by a separate monitor process.
module tb_pmod_enc_axil_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] r0, r1, r2, r3;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_r [$];
  logic [1:0]  exp_b [$];

  always #5 clk = ~clk;

  pmod_enc_axil_regs dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg0_o(r0), .reg1_o(r1), .reg2_o(r2), .reg3_o(r3)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each completed response handshake
  always @(negedge clk) begin
    if (bvalid && bready) begin
      if (exp_b.size() == 0) begin
        chk("unexpected_b", 32'd1, 32'd0);
      end else begin
        chk("bresp", {30'd0, bresp}, {30'd0, exp_b.pop_front()});
      end
    end
    if (rvalid && rready) begin
      if (exp_r.size() == 0) begin
        chk("unexpected_r", 32'd1, 32'd0);
      end else begin
        chk("rresp", {30'd0, rresp}, 32'd0);
        chk("rdata", rdata, exp_r.pop_front());
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain;
    int n = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    bit aw_d = 0;
    bit w_d = 0;
    int n = 0;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1; wvalid = 1;
    exp_b.push_back(2'b00);
    while (!(aw_d && w_d) && n < 50) begin
      @(negedge clk);
      if (awvalid && awready) aw_d = 1;
      if (wvalid && wready) w_d = 1;
      step();
      if (aw_d) awvalid = 0;
      if (w_d) wvalid = 0;
      n++;
    end
    if (n >= 50) chk("wr_timeout", 32'd1, 32'd0);
    awvalid = 0; wvalid = 0;
    wait_drain();
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e);
    int n = 0;
    bit done = 0;
    araddr = a; arvalid = 1;
    exp_r.push_back(e);
    while (!done && n < 50) begin
      @(negedge clk);
      if (arready) done = 1;
      step();
      n++;
    end
    if (!done) chk("rd_timeout", 32'd1, 32'd0);
    arvalid = 0;
    wait_drain();
  endtask

  initial begin
    logic [31:0] strb_exp;
    rst = 1; awaddr = 0; araddr = 0; awprot = 0; arprot = 0;
    awvalid = 0; wvalid = 0; wdata = 0; wstrb = 0;
    bready = 1; arvalid = 0; rready = 1;
    step(); step();
    @(negedge clk);
    chk("rst_ready", {29'd0, awready, wready, arready}, 32'd0);
    chk("rst_valid", {30'd0, bvalid, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_reg0", r0, 32'd0);
    step();
    rst = 0;
    step();

    // 1: basic write/read
    wr(4'h0, 32'h0101FFFF, 4'hF);
    rd(4'h0, 32'h0101FFFF);

    // 2: all four registers, including ignored low address bits
    wr(4'h4, 32'hABCD0001, 4'hF);
    rd(4'h4, 32'hABCD0001);
    wr(4'h8, 32'hDEAD0011, 4'hF);
    rd(4'h8, 32'hDEAD0011);
    wr(4'hF, 32'hBEEF0011, 4'hF);
    rd(4'hC, 32'hBEEF0011);
    rd(4'h1, 32'h0101FFFF);
    rd(4'h4, 32'hABCD0001);
    rd(4'hA, 32'hDEAD0011);
    rd(4'hC, 32'hBEEF0011);
    chk("reg0_o", r0, 32'h0101FFFF);
    chk("reg1_o", r1, 32'hABCD0001);
    chk("reg2_o", r2, 32'hDEAD0011);
    chk("reg3_o", r3, 32'hBEEF0011);

    // 3: W three cycles ahead of AW
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1;
    @(negedge clk);
    chk("w_early_ready", {31'd0, wready}, 32'd1);
    step();
    wvalid = 0;
    repeat (3) begin
      @(negedge clk);
      chk("w_held_noready", {31'd0, wready}, 32'd0);
      chk("w_held_nob", {31'd0, bvalid}, 32'd0);
      step();
    end
    awaddr = 4'h4; awvalid = 1;
    exp_b.push_back(2'b00);
    @(negedge clk);
    chk("aw_late_ready", {31'd0, awready}, 32'd1);
    step();
    awvalid = 0;
    @(negedge clk);
    chk("b_after_aw", {31'd0, bvalid}, 32'd1);
    chk("reg1_commit", r1, 32'h12345678);
    step();
    wait_drain();
    rd(4'h4, 32'h12345678);

    // 4: BREADY held low blocks the next write
    bready = 0;
    awaddr = 4'h8; wdata = 32'h0BADF00D; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    exp_b.push_back(2'b00);
    step();
    awvalid = 0; wvalid = 0;
    repeat (5) begin
      @(negedge clk);
      chk("bhold_valid", {31'd0, bvalid}, 32'd1);
      chk("bhold_ready", {30'd0, awready, wready}, 32'd0);
      step();
    end
    awaddr = 4'hC; wdata = 32'hCAFE0042;
    awvalid = 1; wvalid = 1;
    exp_b.push_back(2'b00);
    step();
    chk("blocked_reg3", r3, 32'hBEEF0011);
    bready = 1;
    begin
      int n = 0;
      while (awvalid && n < 20) begin
        @(negedge clk);
        if (awready) begin
          step();
          awvalid = 0; wvalid = 0;
        end else begin
          step();
        end
        n++;
      end
      if (awvalid) chk("bhold_timeout", 32'd1, 32'd0);
      awvalid = 0; wvalid = 0;
    end
    wait_drain();
    rd(4'h8, 32'h0BADF00D);
    rd(4'hC, 32'hCAFE0042);

    // 5: byte strobes
`ifdef PMOD_ENC_WSTRB_EN
    strb_exp = 32'hFF00FF00;
`else
    strb_exp = 32'h00000000;
`endif
    wr(4'h0, 32'hFFFFFFFF, 4'hF);
    wr(4'h0, 32'h00000000, 4'b0101);
    rd(4'h0, strb_exp);
    wr(4'h0, 32'h13572468, 4'b0000);
`ifdef PMOD_ENC_WSTRB_EN
    rd(4'h0, 32'hFF00FF00);
`else
    rd(4'h0, 32'h13572468);
`endif

    // 6: reset while a read response is stalled
    rready = 0;
    araddr = 4'h4; arvalid = 1;
    step();
    arvalid = 0;
    @(negedge clk);
    chk("rstall_valid", {31'd0, rvalid}, 32'd1);
    chk("rstall_data", rdata, 32'h12345678);
    step();
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    chk("post_rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("post_rst_regs", r0 | r1 | r2 | r3, 32'd0);
    step();
    rready = 1;
    rd(4'h0, 32'd0);
    rd(4'h4, 32'd0);
    rd(4'h8, 32'd0);
    rd(4'hC, 32'd0);

    chk("sb_b_empty", exp_b.size(), 32'd0);
    chk("sb_r_empty", exp_r.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
